seg7_scan: RTL

Time-multiplexed driver for a 4-digit common-anode seven-segment display, placed directly downstream of `clock_divider`. It consumes the divider's `clk_1khz` output as a scan rate and runs entirely in the `clk_in` domain. On each detected `clk_1khz` rising edge it advances to the next digit and drives the active-low anode, segment and decimal-point lines. It latches a full 16-bit frame once per scan so the display never tears.

---
 rtl/seg7_scan.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Four-digit common-anode seven-segment scanner driven by a synchronised 1 kHz scan strobe.
// Optional leading-zero blanking is compiled in when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        clk_1khz,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        scan_wrap
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   tick;

    logic [1:0]  idx_reg;
    logic [1:0]  idx_next;
    logic [15:0] frame_reg;
    logic [15:0] frame_next;
    logic [3:0]  dpl_reg;
    logic [3:0]  dpl_next;
    logic        wrap_next;

    logic [3:0]  nib [4];
    logic [3:0]  lz_blank;

    logic [3:0]  an_next;
    logic [6:0]  seg_next;
    logic        dp_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // clk_1khz is asynchronous: shift it through the chain, then keep one history bit for rise detect.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], clk_1khz};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign tick = sync_reg[SYNC_STAGES-1] & ~hist_reg;

    always_comb begin
        idx_next   = tick ? idx_reg + 2'd1 : idx_reg;
        wrap_next  = tick && (idx_next == 2'd0);
        frame_next = wrap_next ? digits : frame_reg;
        dpl_next   = wrap_next ? dp_in : dpl_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = frame_next[gi*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            // A digit is blank when it and every more-significant digit of the latched frame is zero.
            if (gi == 0) begin : g_keep
                assign lz_blank[gi] = 1'b0;
            end else begin : g_lz
                assign lz_blank[gi] = (frame_next[15:gi*4] == '0);
            end
`else
            assign lz_blank[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        an_next  = 4'b1111;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (en && !lz_blank[idx_next]) begin
            an_next  = ~(4'b0001 << idx_next);
            seg_next = hex_to_seg(nib[idx_next]);
            dp_next  = ~dpl_next[idx_next];
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            idx_reg   <= 2'd3;
            frame_reg <= '0;
            dpl_reg   <= '0;
            an        <= 4'b1111;
            seg       <= 7'h7F;
            dp        <= 1'b1;
            scan_wrap <= 1'b0;
        end else begin
            idx_reg   <= idx_next;
            frame_reg <= frame_next;
            dpl_reg   <= dpl_next;
            an        <= an_next;
            seg       <= seg_next;
            dp        <= dp_next;
            scan_wrap <= wrap_next;
        end
    end

endmodule
